// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg
//   Shared definitions for the register-file ALU processor: opcode encodings,
//   the sequencing FSM state type, and per-opcode decode helpers telling the
//   datapath which register-file ports an opcode reads and whether it writes.
package reg_alu_pkg;

  localparam logic [2:0] OP_WR    = 3'd0;  // write external data
  localparam logic [2:0] OP_RD1   = 3'd1;  // read R1
  localparam logic [2:0] OP_RD2   = 3'd2;  // read R1 and R2
  localparam logic [2:0] OP_RDWR  = 3'd3;  // read R1, write external data
  localparam logic [2:0] OP_RD2WR = 3'd4;  // read R1 and R2, write external data
  localparam logic [2:0] OP_ADD   = 3'd5;  // write R1 + R2
  localparam logic [2:0] OP_SUB   = 3'd6;  // write R1 - R2
  localparam logic [2:0] OP_SHL   = 3'd7;  // write R1 << SHIFT

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Opcode reads register file port 1.
  function automatic logic uses_rd1(input logic [2:0] op);
    logic r;
    case (op)
      OP_WR:   r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Opcode reads register file port 2.
  function automatic logic uses_rd2(input logic [2:0] op);
    logic r;
    case (op)
      OP_RD2, OP_RD2WR, OP_ADD, OP_SUB: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcode writes back to the register file.
  function automatic logic writes(input logic [2:0] op);
    logic r;
    case (op)
      OP_RD1, OP_RD2: r = 1'b0;
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_alu_processor_alu_regfile.sv
// alu_regfile
//   DEPTH x WIDTH register file with two asynchronous read ports and one
//   synchronous write port. All entries clear to zero on synchronous reset;
//   reset takes priority over a coincident write.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   we, wr_addr, wr_data write enable / address / data (captured on clk rise)
//   rd_addr1, rd_data1  read port 1 (combinational)
//   rd_addr2, rd_data2  read port 2 (combinational)
module alu_regfile #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Register storage: clear on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = mem_r[rd_addr1];
  assign rd_data2 = mem_r[rd_addr2];

endmodule

// File: rtl/reg_alu_processor.sv
// reg_alu_processor
//   Handshaked instruction processor. Each accepted opcode runs a fixed
//   READ -> EXEC -> WRITE sequence on an internal register file and then
//   pulses done for one cycle. Inputs are captured at acceptance, so the
//   producer may change them freely afterwards.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (ready only while idle)
//   opcode                operation code
//   rd_addr1, rd_addr2    operand register addresses
//   wr_addr, wr_data_in   writeback address, external write data
//   read_data1/2          operands of the last transaction (0 if port unused)
//   result                value written back (0 if no write)
//   overflow              signed overflow of add/sub
//   done                  one-cycle completion pulse
module reg_alu_processor
  import reg_alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  parameter  int SHIFT = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data_in,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             done
);

  state_t           state_r;
  logic [2:0]       op_r;
  logic [AW-1:0]    ra1_r;
  logic [AW-1:0]    ra2_r;
  logic [AW-1:0]    wa_r;
  logic [WIDTH-1:0] wd_r;

  logic [WIDTH-1:0] rf_rd1_s;
  logic [WIDTH-1:0] rf_rd2_s;
  logic             rf_we_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;

  // The write lands on the edge that leaves WRITE; reads happened two edges
  // earlier, which gives read-before-write on a shared address for free.
  assign rf_we_s = (state_r == ST_WRITE) && writes(op_r);

  alu_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we_s),
    .wr_addr  (wa_r),
    .wr_data  (result),
    .rd_addr1 (ra1_r),
    .rd_data1 (rf_rd1_s),
    .rd_addr2 (ra2_r),
    .rd_data2 (rf_rd2_s)
  );

  assign sum_s  = read_data1 + read_data2;
  assign diff_s = read_data1 - read_data2;

  // ALU: operates on the registered operands captured in READ.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (op_r)
      OP_WR, OP_RDWR, OP_RD2WR: begin
        alu_res_s = wd_r;
      end
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (read_data1[WIDTH-1] == read_data2[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != read_data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (read_data1[WIDTH-1] != read_data2[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != read_data1[WIDTH-1]);
      end
      OP_SHL: begin
        alu_res_s = read_data1 << SHIFT;
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // Sequencing FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      in_ready   <= 1'b1;
      done       <= 1'b0;
      op_r       <= 3'd0;
      ra1_r      <= {AW{1'b0}};
      ra2_r      <= {AW{1'b0}};
      wa_r       <= {AW{1'b0}};
      wd_r       <= {WIDTH{1'b0}};
      read_data1 <= {WIDTH{1'b0}};
      read_data2 <= {WIDTH{1'b0}};
      result     <= {WIDTH{1'b0}};
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r     <= opcode;
            ra1_r    <= rd_addr1;
            ra2_r    <= rd_addr2;
            wa_r     <= wr_addr;
            wd_r     <= wr_data_in;
            in_ready <= 1'b0;
            state_r  <= ST_READ;
          end
        end
        ST_READ: begin
          read_data1 <= uses_rd1(op_r) ? rf_rd1_s : {WIDTH{1'b0}};
          read_data2 <= uses_rd2(op_r) ? rf_rd2_s : {WIDTH{1'b0}};
          state_r    <= ST_EXEC;
        end
        ST_EXEC: begin
          result   <= alu_res_s;
          overflow <= alu_ovf_s;
          state_r  <= ST_WRITE;
        end
        ST_WRITE: begin
          done     <= 1'b1;
          in_ready <= 1'b1;
          state_r  <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_alu_processor.md
Name: reg_alu_processor

Overview:
- Parametrised, handshaked successor of the instruction processor.
- Accepts one 3-bit opcode per transaction and performs a fixed-latency read → execute → writeback sequence on an internal register file of DEPTH × WIDTH registers.
- Reports the read operands, the ALU result and an overflow flag with a one-cycle done pulse.
- Sits between the instruction sequencer (producer) and result consumers.

Parameters:
- WIDTH, 16, data width of registers and ALU.
- DEPTH, 8, number of registers (power of two, ≥2).
- AW, $clog2(DEPTH), address width (derived, not overridden).
- SHIFT, 1, left-shift amount for opcode 7 (0..WIDTH-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept; high only in IDLE
- opcode  in  3  operation code
- rd_addr1  in  AW  first read address
- rd_addr2  in  AW  second read address
- wr_addr  in  AW  write address
- wr_data_in  in  WIDTH  external write data (opcodes 0, 3, 4)
- read_data1  out  WIDTH  operand 1 of last transaction
- read_data2  out  WIDTH  operand 2 of last transaction
- result  out  WIDTH  value written back (0 if no write)
- overflow  out  1  signed overflow of add/sub, else 0
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE, in_ready=1, done=0, read_data1/2=0, result=0, overflow=0, all registers 0.
- Reset mid-transaction: abandons it; no writeback and no done pulse.
- FSM: IDLE → READ → EXEC → WRITE → IDLE.
  - IDLE: transaction accepted on the edge where in_valid && in_ready. opcode, addresses and wr_data_in are captured; later input changes are ignored.
  - READ: asynchronous regfile reads of the captured addresses. Operands are registered for used ports only; unused read_dataN holds 0.
  - EXEC: result and overflow are registered.
  - WRITE: regfile write (if the opcode writes) on this edge; done=1 for the following cycle. in_ready returns to 1 in that same cycle.
- Latency: accept at edge k → done high in the cycle after edge k+3. Back-to-back issue is one transaction per 4 cycles.
- Opcodes (R1=reg[rd_addr1], R2=reg[rd_addr2]):
  - 0: write wr_data_in; no reads.
  - 1: read R1.
  - 2: read R1, R2.
  - 3: read R1, write wr_data_in.
  - 4: read R1, R2, write wr_data_in.
  - 5: write R1+R2 mod 2^WIDTH.
  - 6: write R1−R2 mod 2^WIDTH.
  - 7: write R1<<SHIFT, zero-fill, bits shifted out discarded.
- result equals the written value; it is 0 for opcodes 1 and 2.
- overflow (two's complement):
  - opcode 5: 1 when operand signs are equal and the sum sign differs.
  - opcode 6: 1 when operand signs differ and the result sign differs from R1.
  - 0 for all other opcodes.
- Read-before-write: when wr_addr equals a read address, reads return the pre-write value.
- The next transaction sees all prior writes, with no hazard.
- Same address on rd_addr1 and rd_addr2 is legal; both operands are equal.
- in_valid while busy is ignored; the producer must hold the request until accepted.
- done is never high during reset or for two consecutive cycles.

Decomposition:
- Package reg_alu_pkg: opcode constants OP_WR, OP_RD1, OP_RD2, OP_RDWR, OP_RD2WR, OP_ADD, OP_SUB, OP_SHL; FSM state enum; per-opcode helpers uses_rd1, uses_rd2, writes.
- One sub-module, alu_regfile: DEPTH × WIDTH, two asynchronous read ports, one synchronous write port with enable, synchronous reset to 0.
- FSM and ALU stay in the top module.

Test Plan:
- Reset then opcode 0, wr_addr=3, wr_data_in=16'h1234; then opcode 1, rd_addr1=3 → read_data1=16'h1234, done exactly 4 cycles after accept.
- reg1=16'h7FFF, reg2=16'h0001, opcode 5, wr_addr=4 → result=16'h8000, overflow=1; subsequent opcode 1 on addr 4 reads 16'h8000.
- reg1=16'h0003, reg2=16'h0005, opcode 6 → result=16'hFFFE, overflow=0; reg1=16'h8000, reg2=1, opcode 6 → 16'h7FFF, overflow=1.
- reg5=16'hC001, opcode 7, SHIFT=1, wr_addr=5 → result=16'h8002, and reg5 updates in place.
- opcode 3, rd_addr1=wr_addr=2, old reg2=16'hAAAA, wr_data_in=16'h5555 → read_data1=16'hAAAA, later read of reg2=16'h5555.
- Assert rst in the EXEC state of opcode 0 → no done, target register unchanged; in_valid held during busy cycles accepted only once.
